tx_burst_sequencer: RTL
=======================

// Module: tx_burst_sequencer
// PURPOSE
//  Sequences the backscatter bit modulator: waits for an excitation-packet detect pulse, waits a
//  programmable start delay, then holds the modulator's trigger high for exactly N bit periods.
//  It then enforces a guard interval before re-arming. Sits between the packet/energy detector
//  and the bit-rate modulator.
// PARAMETERS
//  CLKS_PER_BIT  50   clocks per backscattered bit; must match the modulator's bit divider
//  DLY_W         16   width of start-delay and guard counters
//  NB_W          10   width of bit-count field (max 1023 bits per burst)
//  CNT_W         16   width of statistics counters
// PORTS
//  clock          in   1      system clock
//  reset          in   1      asynchronous, active-low reset
//  pkt_detect     in   1      1-cycle pulse: excitation packet start detected
//  cfg_enable     in   1      level; 0 = disarm and abort any burst
//  cfg_delay      in   DLY_W  clocks from detect to trigger rise
//  cfg_num_bits   in   NB_W   bits per burst
//  cfg_guard      in   DLY_W  idle clocks after burst before re-arm
//  trigger        out  1      drives modulator trigger; high only during TX
//  busy           out  1      high in any state other than IDLE
//  tx_done        out  1      1-cycle pulse on completed burst
//  tx_abort       out  1      1-cycle pulse when a burst is cut short by cfg_enable=0
//  burst_count    out  CNT_W  completed bursts, saturating
//  miss_count     out  CNT_W  pkt_detect pulses ignored while busy, saturating
// BEHAVIOUR
//  - Reset: state=IDLE; trigger, busy, tx_done, tx_abort = 0; counters = 0. All outputs registered.
//  - States: IDLE, DELAY, TX, GUARD.
//  - IDLE: on pkt_detect & cfg_enable, latch cfg_delay/num_bits/guard.
//    Go to DELAY, or to TX if cfg_delay==0. Config changes after the latch have no effect
//    until the next accept.
//  - Timing: detect in cycle k -> trigger=1 from cycle k+1+cfg_delay. Trigger stays high for
//    exactly cfg_num_bits*CLKS_PER_BIT consecutive cycles, then falls.
//  - Bit timing: a bit-phase counter runs 0..CLKS_PER_BIT-1; a bit counter increments on wrap.
//    TX ends when the bit counter reaches the latched num_bits on a wrap.
//  - GUARD is entered on the cycle trigger falls. tx_done pulses on the first GUARD cycle and
//    burst_count increments there. GUARD lasts cfg_guard cycles (0 -> straight to IDLE).
//  - cfg_num_bits==0 at accept: burst is rejected. Stay IDLE, no trigger, no count, no pulses.
//  - pkt_detect while busy: ignored; miss_count +1, saturating at all-ones.
//    A detect on the final GUARD cycle is also ignored and counted; re-arm is effective the
//    following cycle.
//  - cfg_enable=0 in DELAY or GUARD: next state IDLE, no pulse.
//    cfg_enable=0 in TX: trigger=0 next cycle, tx_abort pulse, state IDLE, no guard,
//    burst_count unchanged.
//  - Saturating counters never wrap. Product num_bits*CLKS_PER_BIT is never formed; nested
//    counters only.
//  - Reset asserted mid-burst: trigger drops asynchronously; latched config is cleared.
// STRUCTURE
//  - Shared include tx_seq_defs.vh: state encodings (IDLE=0, DELAY=1, TX=2, GUARD=3),
//    default CLKS_PER_BIT.
//  - One sub-module, seq_bit_timer: bit-phase + bit counters with start/clear inputs and a
//    done output.
//  - The top holds the FSM, config latches and statistics counters.
// TESTING
//  1 Basic: delay=10, bits=4, guard=20, detect at cycle 100 -> trigger high cycles 111..310
//    (200 cycles), tx_done at 311, busy low from 331, burst_count=1.
//  2 Zero delay/guard: delay=0, bits=1, guard=0 -> trigger high exactly 50 cycles starting the
//    cycle after detect; IDLE the cycle after tx_done.
//  3 Busy overlap: detect during DELAY, during TX and on the last GUARD cycle -> single burst,
//    miss_count=3. A detect one cycle later is accepted.
//  4 Abort: drop cfg_enable at bit 2 of 8 -> trigger low next cycle, tx_abort pulse,
//    burst_count unchanged, no tx_done.
//  5 Rejects/saturation: bits=0 -> no trigger, no count.
//    Preload miss_count near max (CNT_W=4), 20 ignored detects -> holds at 15.
//  6 Async reset mid-TX -> trigger and busy low immediately.
//    After release, a new detect produces a full-length burst.

Source files
------------

// File: rtl/tx_burst_sequencer_pkg.sv
// Shared types and defaults for the backscatter burst sequencer.
// State encodings are fixed so they can be matched against captures from the modulator side.
package tx_burst_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_TX    = 2'd2,
    ST_GUARD = 2'd3
  } state_e;

  localparam int CLKS_PER_BIT_DEF = 50;

endpackage

// File: rtl/tx_burst_sequencer_if.sv
// Detector/config/modulator bundle for tx_burst_sequencer.
// Suffixes are from the sequencer's point of view: slave = sequencer, master = its environment.
interface tx_seq_if #(
  parameter int DLY_W = 16,
  parameter int NB_W  = 10,
  parameter int CNT_W = 16
);
  logic             pkt_detect_i;
  logic             cfg_enable_i;
  logic [DLY_W-1:0] cfg_delay_i;
  logic [NB_W-1:0]  cfg_num_bits_i;
  logic [DLY_W-1:0] cfg_guard_i;
  logic             trigger_o;
  logic             busy_o;
  logic             tx_done_o;
  logic             tx_abort_o;
  logic [CNT_W-1:0] burst_count_o;
  logic [CNT_W-1:0] miss_count_o;

  modport slave (
    input  pkt_detect_i, cfg_enable_i, cfg_delay_i, cfg_num_bits_i, cfg_guard_i,
    output trigger_o, busy_o, tx_done_o, tx_abort_o, burst_count_o, miss_count_o
  );

  modport master (
    output pkt_detect_i, cfg_enable_i, cfg_delay_i, cfg_num_bits_i, cfg_guard_i,
    input  trigger_o, busy_o, tx_done_o, tx_abort_o, burst_count_o, miss_count_o
  );
endinterface

// File: rtl/tx_burst_sequencer_seq_bit_timer.sv
// Nested bit-phase / bit counters; done_o flags the last clock of the last bit so the
// caller can drop trigger on the following edge without ever forming num_bits*CLKS_PER_BIT.
module seq_bit_timer #(
  parameter int CLKS_PER_BIT = 50,
  parameter int NB_W         = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            run_i,
  input  logic            clear_i,
  input  logic [NB_W-1:0] num_bits_i,
  output logic            done_o
);
  localparam int PH_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKS_PER_BIT - 1);

  logic [PH_W-1:0] phase_q, phase_d;
  logic [NB_W-1:0] bit_q, bit_d;
  logic            wrap;

  assign wrap   = run_i && (phase_q == PH_LAST);
  assign done_o = wrap && ((bit_q + NB_W'(1)) == num_bits_i);

  always_comb begin
    phase_d = phase_q;
    bit_d   = bit_q;
    if (clear_i) begin
      phase_d = '0;
      bit_d   = '0;
    end else if (run_i) begin
      if (wrap) begin
        phase_d = '0;
        bit_d   = bit_q + NB_W'(1);
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      bit_q   <= '0;
    end else begin
      phase_q <= phase_d;
      bit_q   <= bit_d;
    end
  end
endmodule

// File: rtl/tx_burst_sequencer.sv
// Burst sequencer: detect -> start delay -> N bit periods of trigger -> guard -> re-arm.
// FSM, latched config and saturating statistics; bit timing lives in seq_bit_timer.
module tx_burst_sequencer
  import tx_burst_sequencer_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DLY_W        = 16,
  parameter int NB_W         = 10,
  parameter int CNT_W        = 16
) (
  input logic     clock_i,
  input logic     reset_i,
  tx_seq_if.slave bus
);
  state_e           state_q;
  logic [DLY_W-1:0] cnt_q;
  logic [DLY_W-1:0] guard_q;
  logic [NB_W-1:0]  nbits_q;
  logic             trigger_q, busy_q, done_q, abort_q;
  logic [CNT_W-1:0] burst_q, miss_q;
  logic             tmr_run, tmr_clr, bit_done;

  assign tmr_run = (state_q == ST_TX);
  assign tmr_clr = (state_q != ST_TX);

  seq_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .NB_W        (NB_W)
  ) u_timer (
    .clk_i     (clock_i),
    .rst_ni    (reset_i),
    .run_i     (tmr_run),
    .clear_i   (tmr_clr),
    .num_bits_i(nbits_q),
    .done_o    (bit_done)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      guard_q   <= '0;
      nbits_q   <= '0;
      trigger_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      burst_q   <= '0;
      miss_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      // Any detect outside IDLE is dropped, including one on the final guard cycle.
      if (state_q != ST_IDLE && bus.pkt_detect_i && miss_q != '1)
        miss_q <= miss_q + CNT_W'(1);
      case (state_q)
        ST_IDLE: begin
          if (bus.pkt_detect_i && bus.cfg_enable_i && bus.cfg_num_bits_i != '0) begin
            nbits_q <= bus.cfg_num_bits_i;
            guard_q <= bus.cfg_guard_i;
            busy_q  <= 1'b1;
            if (bus.cfg_delay_i == '0) begin
              state_q   <= ST_TX;
              trigger_q <= 1'b1;
            end else begin
              state_q <= ST_DELAY;
              cnt_q   <= bus.cfg_delay_i;
            end
          end
        end
        ST_DELAY: begin
          if (!bus.cfg_enable_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == DLY_W'(1)) begin
            state_q   <= ST_TX;
            trigger_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - DLY_W'(1);
          end
        end
        ST_TX: begin
          if (!bus.cfg_enable_i) begin
            state_q   <= ST_IDLE;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
            abort_q   <= 1'b1;
          end else if (bit_done) begin
            state_q   <= ST_GUARD;
            trigger_q <= 1'b0;
            done_q    <= 1'b1;
            cnt_q     <= guard_q;
            if (burst_q != '1) burst_q <= burst_q + CNT_W'(1);
          end
        end
        ST_GUARD: begin
          // The tx_done cycle is always spent in GUARD, so guard=0 and guard=1 behave alike.
          if (!bus.cfg_enable_i || cnt_q <= DLY_W'(1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - DLY_W'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          trigger_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trigger_o     = trigger_q;
  assign bus.busy_o        = busy_q;
  assign bus.tx_done_o     = done_q;
  assign bus.tx_abort_o    = abort_q;
  assign bus.burst_count_o = burst_q;
  assign bus.miss_count_o  = miss_q;
endmodule
